// File: rtl/pin_entry_ctrl_pkg.sv
// Shared definitions for the keypad passcode controller: digit geometry and FSM states.
package pin_pkg;
    localparam int PIN_LEN = 4;
    localparam int DIGIT_W = 4;
    localparam int KEY_W   = DIGIT_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_LOCKOUT = 3'd5
    } pin_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/pin_entry_ctrl_if.sv
// Keypad-side and status signals of the passcode controller.
interface pin_entry_ctrl_if;
    logic [pin_pkg::KEY_W-1:0] key_code;
    logic                      enter;
    logic                      clr;
    logic                      mode;
    logic                      unlock;
    logic                      deny;
    logic                      alarm;
    logic                      code_saved;
    logic [2:0]                digit_cnt;
    logic [1:0]                tries;

    modport master (
        output key_code, enter, clr, mode,
        input  unlock, deny, alarm, code_saved, digit_cnt, tries
    );
    modport slave (
        input  key_code, enter, clr, mode,
        output unlock, deny, alarm, code_saved, digit_cnt, tries
    );
endinterface

// File: rtl/pin_entry_ctrl_edge.sv
// Rising-edge detector on the keypad valid bit; a key held through reset release is not a press.
module key_edge_det
    import pin_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_W-1:0]   key_code,
    output logic               key_stb,
    output logic [DIGIT_W-1:0] key_digit
);
    logic prev_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_vld <= 1'b1;
        else        prev_vld <= key_code[KEY_W-1];
    end

    assign key_stb   = key_code[KEY_W-1] & ~prev_vld;
    assign key_digit = key_code[DIGIT_W-1:0];
endmodule

// File: rtl/pin_entry_ctrl.sv
// Keypad passcode controller: digit buffer, compare, unlock/relock, retry count and timed lockout.
module pin_entry_ctrl #(
    parameter int PIN_LEN     = pin_pkg::PIN_LEN,
    parameter int MAX_TRIES   = 3,
    parameter int OPEN_CYCLES = 1000,
    parameter int LOCK_CYCLES = 10000,
    parameter logic [PIN_LEN*pin_pkg::DIGIT_W-1:0] DEFAULT_PIN = 16'h1234
) (
    input logic clk,
    input logic rst_n,
    pin_entry_ctrl_if.slave bus
);
    import pin_pkg::*;

    localparam int         BUF_W    = PIN_LEN * DIGIT_W;
    localparam int         TMR_W    = $clog2(max_int(OPEN_CYCLES, LOCK_CYCLES) + 1);
    localparam logic [2:0] FULL_CNT = 3'(PIN_LEN);

    pin_state_t         state_q, state_d;
    logic [BUF_W-1:0]   dig_buf_q, pass_q;
    logic [2:0]         cnt_q;
    logic [1:0]         tries_q;
    logic [TMR_W-1:0]   tmr_q;
    logic               save_q;

    logic               key_stb;
    logic [DIGIT_W-1:0] key_digit;
    logic full, key_take, match, last_try, open_done, lock_done, save_now, timed, buf_clr;

    key_edge_det u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_code  (bus.key_code),
        .key_stb   (key_stb),
        .key_digit (key_digit)
    );

    // clr and enter both outrank a key edge landing in the same cycle
    assign full      = (cnt_q == FULL_CNT);
    assign key_take  = key_stb && (key_digit <= DIGIT_W'(9)) && !full && !bus.clr && !bus.enter
                       && (state_q inside {ST_IDLE, ST_ENTRY, ST_OPEN});
    assign match     = full && (dig_buf_q == pass_q);
    assign last_try  = (int'(tries_q) + 1 == MAX_TRIES);
    assign open_done = (tmr_q == TMR_W'(OPEN_CYCLES - 1));
    assign lock_done = (tmr_q == TMR_W'(LOCK_CYCLES - 1));
    assign save_now  = (state_q == ST_OPEN) && !bus.clr && bus.enter && bus.mode && full;
    assign timed     = (state_q inside {ST_OPEN, ST_LOCKOUT});
    assign buf_clr   = (state_q == ST_CHECK)
                       || ((state_q inside {ST_ENTRY, ST_OPEN}) && bus.clr)
                       || ((state_q == ST_OPEN) && (state_d != ST_OPEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // A short entry still passes through CHECK so deny keeps the same latency as a real mismatch
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (key_take) state_d = ST_ENTRY;
            ST_ENTRY: begin
                if (bus.clr)        state_d = ST_IDLE;
                else if (bus.enter) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (match)         state_d = ST_OPEN;
                else if (last_try) state_d = ST_LOCKOUT;
                else               state_d = ST_FAIL;
            end
            ST_OPEN: begin
                if (bus.clr)        state_d = ST_OPEN;
                else if (bus.enter) begin
                    if (!bus.mode || full) state_d = ST_IDLE;
                end
                else if (open_done) state_d = ST_IDLE;
            end
            ST_FAIL:    state_d = ST_IDLE;
            ST_LOCKOUT: if (lock_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.unlock     = (state_q == ST_OPEN);
        bus.deny       = (state_q == ST_FAIL);
        bus.alarm      = (state_q == ST_LOCKOUT);
        bus.code_saved = save_q;
        bus.digit_cnt  = cnt_q;
        bus.tries      = tries_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_buf_q <= '0;
            cnt_q     <= '0;
            pass_q    <= DEFAULT_PIN;
            save_q    <= 1'b0;
        end else begin
            save_q <= save_now;
            if (buf_clr) begin
                dig_buf_q <= '0;
                cnt_q     <= '0;
            end else if (key_take) begin
                dig_buf_q <= {dig_buf_q[BUF_W-DIGIT_W-1:0], key_digit};
                cnt_q     <= cnt_q + 3'd1;
            end
            if (save_now) pass_q <= dig_buf_q;
        end
    end

    // tries holds its last value through lockout and clears on the way out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tries_q <= '0;
            tmr_q   <= '0;
        end else begin
            if (state_q == ST_CHECK)
                tries_q <= match ? 2'd0 : (last_try ? tries_q : tries_q + 2'd1);
            else if ((state_q == ST_LOCKOUT) && (state_d == ST_IDLE))
                tries_q <= '0;
            tmr_q <= (timed && (state_d == state_q)) ? tmr_q + TMR_W'(1) : '0;
        end
    end
endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Scoreboard bench for pin_entry_ctrl: expected output events are queued at enter and matched by a monitor.
module tb_pin_entry_ctrl;
    localparam int OPEN_N    = 8;
    localparam int LOCK_N    = 16;
    localparam int EV_NONE   = 0;
    localparam int EV_UNLOCK = 1;
    localparam int EV_DENY   = 2;
    localparam int EV_ALARM  = 3;
    localparam int EV_SAVED  = 4;

    typedef struct {
        int ev;
        int cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb[$];

    int   ulen = 0, alen = 0, dlen = 0, slen = 0, last_ulen = 0, last_alen = 0;
    logic pu = 1'b0, pa = 1'b0, pd = 1'b0, ps = 1'b0;

    pin_entry_ctrl_if bus();

    pin_entry_ctrl #(
        .OPEN_CYCLES (OPEN_N),
        .LOCK_CYCLES (LOCK_N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic got_ev(input int ev);
        exp_t e;
        if (sb.size() == 0) chk("unexpected_event", ev, EV_NONE);
        else begin
            e = sb.pop_front();
            chk("event_kind", ev, e.ev);
            chk("event_cycle", cyc, e.cyc);
        end
    endtask

    // Output monitor: event onsets go to the scoreboard, pulse widths are checked on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            pu = 1'b0; pa = 1'b0; pd = 1'b0; ps = 1'b0;
            ulen = 0; alen = 0; dlen = 0; slen = 0;
        end else begin
            if (bus.unlock && !pu)     got_ev(EV_UNLOCK);
            if (bus.alarm && !pa)      got_ev(EV_ALARM);
            if (bus.deny && !pd)       got_ev(EV_DENY);
            if (bus.code_saved && !ps) got_ev(EV_SAVED);
            if (bus.unlock) ulen++;
            else if (pu) begin last_ulen = ulen; ulen = 0; end
            if (bus.alarm) alen++;
            else if (pa) begin last_alen = alen; alen = 0; end
            if (bus.deny) dlen++;
            else if (pd) begin chk("deny_width", dlen, 1); dlen = 0; end
            if (bus.code_saved) slen++;
            else if (ps) begin chk("saved_width", slen, 1); slen = 0; end
            pu = bus.unlock; pa = bus.alarm; pd = bus.deny; ps = bus.code_saved;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // key released for one cycle, then pressed; the key stays held afterwards
    task automatic press(input logic [3:0] d);
        bus.key_code = {1'b0, d};
        wait_cyc(1);
        bus.key_code = {1'b1, d};
        wait_cyc(1);
    endtask

    task automatic press_pin(input logic [15:0] p);
        for (int i = 3; i >= 0; i--) press(p[i*4 +: 4]);
    endtask

    task automatic enter_pin(input logic m, input int ev);
        bus.enter = 1'b1;
        bus.mode  = m;
        if (ev == EV_SAVED)     sb.push_back('{ev, cyc + 1});
        else if (ev != EV_NONE) sb.push_back('{ev, cyc + 2});
        wait_cyc(1);
        bus.enter = 1'b0;
        bus.mode  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (sb.size() != 0 && n < 40);
        #1;
        if (sb.size() != 0) begin
            chk("scoreboard_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
        $fatal(1);
    end

    initial begin
        bus.key_code = 5'h17;
        bus.enter    = 1'b0;
        bus.clr      = 1'b0;
        bus.mode     = 1'b0;
        #1;
        chk("rst_unlock", int'(bus.unlock), 0);
        chk("rst_deny", int'(bus.deny), 0);
        chk("rst_alarm", int'(bus.alarm), 0);
        chk("rst_saved", int'(bus.code_saved), 0);
        chk("rst_cnt", int'(bus.digit_cnt), 0);
        chk("rst_tries", int'(bus.tries), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(3);
        chk("held_through_reset", int'(bus.digit_cnt), 0);

        // key held for many cycles counts once; clr empties; fifth digit is dropped
        bus.key_code = 5'h07;
        wait_cyc(1);
        bus.key_code = 5'h17;
        wait_cyc(10);
        chk("held_key_cnt", int'(bus.digit_cnt), 1);
        bus.key_code = 5'h07;
        bus.clr = 1'b1;
        wait_cyc(1);
        bus.clr = 1'b0;
        wait_cyc(1);
        chk("clr_cnt", int'(bus.digit_cnt), 0);
        press_pin(16'h1234);
        press(4'd9);
        chk("cnt_full", int'(bus.digit_cnt), 4);
        enter_pin(1'b0, EV_UNLOCK);
        drain();
        chk("open_tries", int'(bus.tries), 0);
        wait_cyc(12);
        chk("open_len", last_ulen, OPEN_N);
        chk("open_expired", int'(bus.unlock), 0);

        // three wrong codes: deny, deny, lockout
        for (int k = 0; k < 2; k++) begin
            press_pin(16'h1235);
            enter_pin(1'b0, EV_DENY);
            drain();
            chk("fail_tries", int'(bus.tries), k + 1);
        end
        press_pin(16'h1235);
        enter_pin(1'b0, EV_ALARM);
        drain();
        press(4'd1);
        chk("lock_keys_ignored", int'(bus.digit_cnt), 0);
        wait_cyc(24);
        chk("lock_len", last_alen, LOCK_N);
        chk("lock_tries_clear", int'(bus.tries), 0);
        chk("lock_alarm_off", int'(bus.alarm), 0);

        // program a new code while open, then old fails and new opens
        press_pin(16'h1234);
        enter_pin(1'b0, EV_UNLOCK);
        press_pin(16'h5678);
        enter_pin(1'b1, EV_SAVED);
        drain();
        wait_cyc(2);
        chk("prog_unlock_off", int'(bus.unlock), 0);
        press_pin(16'h1234);
        enter_pin(1'b0, EV_DENY);
        drain();
        chk("old_code_tries", int'(bus.tries), 1);
        press_pin(16'h5678);
        enter_pin(1'b0, EV_UNLOCK);
        drain();
        chk("new_code_tries", int'(bus.tries), 0);
        enter_pin(1'b0, EV_NONE);
        wait_cyc(2);
        chk("relock_len", last_ulen, 2);
        chk("relock_unlock", int'(bus.unlock), 0);

        // short entry is a wrong attempt
        press(4'd1);
        press(4'd2);
        enter_pin(1'b0, EV_DENY);
        drain();
        chk("short_tries", int'(bus.tries), 1);

        // clr wins over enter
        press_pin(16'h5678);
        chk("pre_clr_cnt", int'(bus.digit_cnt), 4);
        bus.clr   = 1'b1;
        bus.enter = 1'b1;
        wait_cyc(1);
        bus.clr   = 1'b0;
        bus.enter = 1'b0;
        wait_cyc(4);
        chk("clr_enter_cnt", int'(bus.digit_cnt), 0);
        chk("clr_enter_tries", int'(bus.tries), 1);
        chk("clr_enter_pending", sb.size(), 0);

        // reset during lockout restores defaults
        press_pin(16'h1234);
        enter_pin(1'b0, EV_DENY);
        drain();
        chk("pre_lock_tries", int'(bus.tries), 2);
        press_pin(16'h1234);
        enter_pin(1'b0, EV_ALARM);
        drain();
        wait_cyc(5);
        chk("mid_lock_alarm", int'(bus.alarm), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_lock_alarm", int'(bus.alarm), 0);
        chk("rst_lock_tries", int'(bus.tries), 0);
        chk("rst_lock_cnt", int'(bus.digit_cnt), 0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);
        press_pin(16'h1234);
        enter_pin(1'b0, EV_UNLOCK);
        drain();
        chk("default_pin_unlock", int'(bus.unlock), 1);
        wait_cyc(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
